// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: dual-write register file with per-register pending bits; define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding
module regfile_scoreboard #(
  parameter int WIDTH = 8,
  parameter int AW = 3,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we4,
  input  logic [AW-1:0]    wa4,
  input  logic [WIDTH-1:0] wd4,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             pend1,
  output logic             pend2,
  input  logic             iss,
  input  logic [AW-1:0]    iss_a,
  output logic             any_pend
);
  localparam int DEPTH = 1 << AW;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend, pend_next;
  logic w3, w4, iss_ok;
  // Accesses aimed at a hardwired-zero register are squashed here once
  assign w3 = we3 && !(ZERO_REG != 0 && wa3 == '0);
  assign w4 = we4 && !(ZERO_REG != 0 && wa4 == '0);
  assign iss_ok = iss && !(ZERO_REG != 0 && iss_a == '0);
  always_comb begin
    pend_next = pend;
    if (w3) pend_next[wa3] = 1'b0;
    if (w4) pend_next[wa4] = 1'b0;
    if (iss_ok) pend_next[iss_a] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
    end else begin
      if (w3) mem[wa3] <= wd3;
      if (w4) mem[wa4] <= wd4;
      pend <= pend_next;
    end
  end
  function automatic logic [WIDTH-1:0] rd_val(input logic [AW-1:0] ra);
    logic [WIDTH-1:0] v;
    v = (ZERO_REG != 0 && ra == '0) ? '0 : mem[ra];
`ifdef REGFILE_BYPASS_EN
    v = (w4 && wa4 == ra) ? wd4 : (w3 && wa3 == ra) ? wd3 : v;
`endif
    return v;
  endfunction
  function automatic logic pend_val(input logic [AW-1:0] ra);
    logic p;
    p = pend[ra];
`ifdef REGFILE_BYPASS_EN
    p = ((w3 && wa3 == ra) || (w4 && wa4 == ra)) ? (iss_ok && iss_a == ra) : p;
`endif
    return p;
  endfunction
  assign rd1 = rd_val(ra1);
  assign rd2 = rd_val(ra2);
  assign pend1 = pend_val(ra1);
  assign pend2 = pend_val(ra2);
  assign any_pend = |pend;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of writes, collisions, pending bits, zero register and reset
module tb_regfile_scoreboard;
  logic clk = 1'b0, reset = 1'b1;
  logic we3 = 0, we4 = 0, iss = 0;
  logic [2:0] wa3 = 0, wa4 = 0, ra1 = 0, ra2 = 0, iss_a = 0;
  logic [7:0] wd3 = 0, wd4 = 0, rd1, rd2;
  logic pend1, pend2, any_pend;
  int total = 0, bad = 0;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .pend1(pend1), .pend2(pend2),
    .iss(iss), .iss_a(iss_a), .any_pend(any_pend)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we3 = 0; we4 = 0; iss = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    step();
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); ra2 = 3'(7 - i);
      #1;
      chk("rst_rd1", rd1, 0);
      chk("rst_rd2", rd2, 0);
      chk("rst_pend1", pend1, 0);
      chk("rst_pend2", pend2, 0);
      chk("rst_any", any_pend, 0);
    end
    we3 = 1; wa3 = 2; wd3 = 8'h5A; we4 = 1; wa4 = 5; wd4 = 8'hC3;
    step();
    idle(); ra1 = 2; ra2 = 5; #1;
    chk("wr_a", rd1, 8'h5A);
    chk("wr_b", rd2, 8'hC3);
    we3 = 1; wa3 = 4; wd3 = 8'h11; we4 = 1; wa4 = 4; wd4 = 8'h22;
    step();
    idle(); ra1 = 4; ra2 = 2; #1;
    chk("collide", rd1, 8'h22);
    chk("collide_other", rd2, 8'h5A);
    iss = 1; iss_a = 3;
    step();
    idle(); ra1 = 3; ra2 = 2; #1;
    chk("iss_pend1", pend1, 1);
    chk("iss_pend2", pend2, 0);
    chk("iss_any", any_pend, 1);
    we3 = 1; wa3 = 3; wd3 = 8'h33; iss = 1; iss_a = 3;
    step();
    idle(); #1;
    chk("setwins_pend", pend1, 1);
    chk("setwins_data", rd1, 8'h33);
    we4 = 1; wa4 = 3; wd4 = 8'h44;
    step();
    idle(); #1;
    chk("clr_pend", pend1, 0);
    chk("clr_any", any_pend, 0);
    chk("clr_data", rd1, 8'h44);
    we3 = 1; wa3 = 0; wd3 = 8'hFF; we4 = 1; wa4 = 0; wd4 = 8'hEE; iss = 1; iss_a = 0;
    step();
    idle(); ra1 = 0; ra2 = 0; #1;
    chk("zero_rd", rd1, 0);
    chk("zero_pend", pend1, 0);
    chk("zero_any", any_pend, 0);
    we3 = 1; wa3 = 1; wd3 = 8'hA1; we4 = 1; wa4 = 7; wd4 = 8'hB7; iss = 1; iss_a = 6;
    step();
    idle(); ra1 = 1; ra2 = 7; #1;
    chk("indep_a", rd1, 8'hA1);
    chk("indep_b", rd2, 8'hB7);
    chk("indep_any", any_pend, 1);
    ra1 = 6; #1;
    chk("indep_pend6", pend1, 1);
    chk("indep_rd6", rd1, 0);
    we3 = 1; wa3 = 6; wd3 = 8'h77; ra1 = 6; ra2 = 6; #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd", rd1, 8'h77);
    chk("byp_pend", pend1, 0);
`else
    chk("byp_rd", rd1, 8'h00);
    chk("byp_pend", pend1, 1);
`endif
    chk("byp_any", any_pend, 1);
    step();
    idle(); #1;
    chk("post_rd", rd1, 8'h77);
    chk("post_pend", pend1, 0);
    chk("post_any", any_pend, 0);
    iss = 1; iss_a = 5;
    step();
    idle(); #1;
    chk("pre_reset_any", any_pend, 1);
    reset = 1; we3 = 1; wa3 = 2; wd3 = 8'h99; iss = 1; iss_a = 4;
    step();
    reset = 0; idle(); ra1 = 2; ra2 = 5; #1;
    chk("midrst_rd1", rd1, 0);
    chk("midrst_rd2", rd2, 0);
    chk("midrst_pend2", pend2, 0);
    chk("midrst_any", any_pend, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
